// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// opcodes, arbiter FSM encoding and the opcode legality check.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 011 and 111 are the only unused encodings.
  function automatic logic op_legal(input logic [2:0] op);
    return op[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/Alu.sv
// Combinational ALU: logic ops, add/sub with overflow (signed or carry/borrow
// depending on unsig) and an a<b compare flag.
module Alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         unsig,
  output logic [W-1:0] aluout,
  output logic         overflow,
  output logic         compout
);

  logic         sub;
  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  always_comb begin
    sub      = (op == OP_SUB);
    b_eff    = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    compout  = unsig ? (a < b) : ($signed(a) < $signed(b));
    aluout   = '0;
    overflow = 1'b0;
    case (op)
      OP_AND: aluout = a & b;
      OP_OR:  aluout = a | b;
      OP_NOR: aluout = ~(a | b);
      OP_XOR: aluout = a ^ b;
      OP_ADD, OP_SUB: begin
        aluout = sum[W-1:0];
        // Unsigned: carry out for ADD, borrow (no carry) for SUB.
        overflow = unsig ? (sum[W] ^ sub)
                         : ((a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Alu between two valid/ready requesters;
// one operation in flight, result returned on a tagged response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic             req_unsig0,
  input  logic             req_unsig1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_compout,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done
);

  state_t           state_reg, state_next;
  logic             prio_reg;
  logic [W-1:0]     a_reg, b_reg;
  logic [2:0]       op_reg;
  logic             unsig_reg, id_reg;
  logic             rsp_id_reg, rsp_ovf_reg, rsp_cmp_reg, rsp_err_reg;
  logic [W-1:0]     rsp_result_reg;
  logic [CNT_W-1:0] ops_done_reg;

  logic             req_any, gnt_id, legal;
  logic [W-1:0]     alu_out;
  logic             alu_ovf, alu_cmp;

  assign req_any = |req_valid;
  assign gnt_id  = req_valid[prio_reg] ? prio_reg : ~prio_reg;
  assign legal   = op_legal(op_reg);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      localparam logic ID = 1'(gi);
      assign req_ready[gi] = (state_reg == ST_IDLE) && req_valid[gi] && (gnt_id == ID);
    end
  endgenerate

  // Alu inputs come only from the latched operands so they never toggle outside EXEC.
  Alu #(.W(W)) u_alu (
    .a        (a_reg),
    .b        (b_reg),
    .op       (op_reg),
    .unsig    (unsig_reg),
    .aluout   (alu_out),
    .overflow (alu_ovf),
    .compout  (alu_cmp)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_any) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      prio_reg       <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      unsig_reg      <= 1'b0;
      id_reg         <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_ovf_reg    <= 1'b0;
      rsp_cmp_reg    <= 1'b0;
      rsp_err_reg    <= 1'b0;
      ops_done_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: if (req_any) begin
          a_reg     <= gnt_id ? req_a1 : req_a0;
          b_reg     <= gnt_id ? req_b1 : req_b0;
          op_reg    <= gnt_id ? req_op1 : req_op0;
          unsig_reg <= gnt_id ? req_unsig1 : req_unsig0;
          id_reg    <= gnt_id;
          prio_reg  <= ~gnt_id;
        end
        ST_EXEC: begin
          rsp_id_reg     <= id_reg;
          rsp_result_reg <= legal ? alu_out : '0;
          rsp_ovf_reg    <= legal & alu_ovf;
          rsp_cmp_reg    <= legal & alu_cmp;
          rsp_err_reg    <= ~legal;
        end
        ST_RESP: if (rsp_ready) ops_done_reg <= ops_done_reg + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign rsp_valid    = (state_reg == ST_RESP);
  assign rsp_id       = rsp_id_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_overflow = rsp_ovf_reg;
  assign rsp_compout  = rsp_cmp_reg;
  assign rsp_err      = rsp_err_reg;
  assign ops_done     = ops_done_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-requester drivers, scoreboard queue of
// expected responses, and a negedge monitor comparing every response.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        unsig;
  } req_t;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        ovf;
    logic        cmp;
    logic        err;
  } exp_t;

  logic        clk, rst_n, rsp_ready;
  logic        v0, v1;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;
  logic        u0, u1;
  logic        rsp_valid, rsp_id, rsp_ovf, rsp_cmp, rsp_err;
  logic [31:0] rsp_result;
  logic [15:0] ops_done;

  // Small-counter instance used only to reach the ops_done wrap quickly.
  logic        w_rst_n;
  logic [1:0]  w_ready;
  logic        w_rsp_valid, w_rsp_id, w_ovf, w_cmp, w_err;
  logic [31:0] w_result;
  logic [3:0]  w_ops_done;

  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  alu_arbiter #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid({v1, v0}), .req_ready(req_ready),
    .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
    .req_op0(op0), .req_op1(op1), .req_unsig0(u0), .req_unsig1(u1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_ovf), .rsp_compout(rsp_cmp),
    .rsp_err(rsp_err), .ops_done(ops_done)
  );

  alu_arbiter #(.W(32), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .req_valid(2'b01), .req_ready(w_ready),
    .req_a0(32'h0000_00FF), .req_b0(32'h0000_0F0F), .req_a1(32'h0), .req_b1(32'h0),
    .req_op0(OP_AND), .req_op1(OP_AND), .req_unsig0(1'b0), .req_unsig1(1'b0),
    .rsp_valid(w_rsp_valid), .rsp_ready(1'b1), .rsp_id(w_rsp_id),
    .rsp_result(w_result), .rsp_overflow(w_ovf), .rsp_compout(w_cmp),
    .rsp_err(w_err), .ops_done(w_ops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Requester 0 driver
  initial begin : drv0
    req_t r;
    int   n;
    v0 = 0; a0 = 0; b0 = 0; op0 = 0; u0 = 0;
    forever begin
      while (q0.size() == 0) @(posedge clk);
      #1;
      r = q0.pop_front();
      a0 = r.a; b0 = r.b; op0 = r.op; u0 = r.unsig; v0 = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[0] && n < 200);
      if (!req_ready[0]) timeout_fail("drv0_grant");
      @(posedge clk);
      #1 v0 = 0;
    end
  end

  // Requester 1 driver
  initial begin : drv1
    req_t r;
    int   n;
    v1 = 0; a1 = 0; b1 = 0; op1 = 0; u1 = 0;
    forever begin
      while (q1.size() == 0) @(posedge clk);
      #1;
      r = q1.pop_front();
      a1 = r.a; b1 = r.b; op1 = r.op; u1 = r.unsig; v1 = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[1] && n < 200);
      if (!req_ready[1]) timeout_fail("drv1_grant");
      @(posedge clk);
      #1 v1 = 0;
    end
  end

  // Monitor: latency, hold stability, grant blocking and scoreboard compare.
  initial begin : monitor
    exp_t        e;
    int          gcyc;
    logic        prev_valid;
    logic [15:0] exp_done;
    gcyc = 0; prev_valid = 0; exp_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done   = 0;
        prev_valid = 0;
      end else begin
        if (req_ready != 2'b00) gcyc = cyc;
        if (rsp_valid && !prev_valid) chk("latency_cycle", cyc, gcyc + 2);
        if (rsp_valid) chk("req_ready_in_resp", req_ready, 2'b00);
        if (rsp_valid && !rsp_ready && sb.size() > 0) chk("hold_result", rsp_result, sb[0].result);
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d result %0h, required no response", rsp_id, rsp_result);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_result", rsp_result, e.result);
            chk("rsp_overflow", rsp_ovf, e.ovf);
            chk("rsp_compout", rsp_cmp, e.cmp);
            chk("rsp_err", rsp_err, e.err);
            chk("ops_done_before", ops_done, exp_done);
            $display("rsp id=%0d result=%h ovf=%0d cmp=%0d err=%0d ops_done=%0d",
                     rsp_id, rsp_result, rsp_ovf, rsp_cmp, rsp_err, ops_done);
            exp_done++;
          end
        end
        prev_valid = rsp_valid;
      end
    end
  end

  task automatic push_req(input int i, input req_t r);
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || v0 || v1) && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (g >= 300) timeout_fail(name);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, rsp_id, 1'b0);
    chk({tag, "_rsp_result"}, rsp_result, 32'h0);
    chk({tag, "_rsp_overflow"}, rsp_ovf, 1'b0);
    chk({tag, "_rsp_compout"}, rsp_cmp, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_ops_done"}, ops_done, 16'h0);
  endtask

  initial begin : stimulus
    int g;
    int k;
    rst_n = 0; w_rst_n = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1;

    // Signed overflow on ADD from requester 0
    push_req(0, '{32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0});
    sb.push_back('{1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0});
    wait_drain("t1_drain");
    chk("t1_ops_done", ops_done, 16'd1);

    // Illegal opcode from requester 1 (also returns prio to 0)
    push_req(1, '{32'h5, 32'h3, 3'b011, 1'b0});
    sb.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 1'b1});
    wait_drain("illegal_drain");
    chk("illegal_ops_done", ops_done, 16'd2);

    // Both valid: grant order 0, 1, 0
    push_req(0, '{32'd10, 32'd3, OP_SUB, 1'b0});
    push_req(0, '{32'h0000_0F00, 32'h0000_00F0, OP_OR, 1'b1});
    push_req(1, '{32'hF0F0_F0F0, 32'hFFFF_0000, OP_XOR, 1'b0});
    sb.push_back('{1'b0, 32'h7, 1'b0, 1'b0, 1'b0});
    sb.push_back('{1'b1, 32'h0F0F_F0F0, 1'b0, 1'b1, 1'b0});
    sb.push_back('{1'b0, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0});
    wait_drain("rr_drain");
    chk("rr_ops_done", ops_done, 16'd5);

    // Back-pressure: response held while rsp_ready is low
    rsp_ready = 0;
    push_req(0, '{32'hFFFF_00FF, 32'h0F0F_0F0F, OP_AND, 1'b1});
    push_req(0, '{32'h3, 32'h5, OP_SUB, 1'b1});
    sb.push_back('{1'b0, 32'h0F0F_000F, 1'b0, 1'b0, 1'b0});
    sb.push_back('{1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0});
    g = 0;
    do begin @(negedge clk); g++; end while (!rsp_valid && g < 50);
    if (!rsp_valid) timeout_fail("hold_rsp_valid");
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_req_ready", req_ready, 2'b00);
    end
    @(posedge clk);
    #1 rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("grant_resume", req_ready, 2'b01);
    wait_drain("hold_drain");
    chk("hold_ops_done", ops_done, 16'd7);

    // Reset during EXEC drops the op; prio returns to 0
    push_req(0, '{32'h1, 32'h1, OP_ADD, 1'b0});
    g = 0;
    do begin @(negedge clk); g++; end while (!req_ready[0] && g < 50);
    if (!req_ready[0]) timeout_fail("rst_grant");
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk_reset_outputs("exec_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    push_req(0, '{32'h0, 32'h0, OP_NOR, 1'b0});
    push_req(1, '{32'hFFFF_FFFF, 32'h2, OP_ADD, 1'b1});
    sb.push_back('{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    sb.push_back('{1'b1, 32'h1, 1'b1, 1'b0, 1'b0});
    wait_drain("post_rst_drain");
    chk("post_rst_ops_done", ops_done, 16'd2);

    // Counter wrap on the 4-bit instance: 15 then 0 after 16 ops
    w_rst_n = 1;
    k = 0;
    g = 0;
    while (k < 16 && g < 200) begin
      @(negedge clk);
      g++;
      if (w_rsp_valid) begin
        @(posedge clk);
        #1 k++;
        if (k == 15) chk("wrap_15", w_ops_done, 4'd15);
        if (k == 16) chk("wrap_0", w_ops_done, 4'd0);
      end
    end
    if (k < 16) timeout_fail("wrap_ops");
    w_rst_n = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's combinational `Alu` between two requesters over valid/ready handshakes. Grants are round-robin, operands are latched and executed one operation at a time, and each result is returned on a single tagged response channel. The block sits between the issue logic and the ALU datapath, and it is the only driver of the ALU's `a`, `b`, `op` and `unsig` inputs.

## Interface
- `W`, 32: operand/result width; fixed to match `Alu`.
- `CNT_W`, 16: width of completed-operation counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid[1:0]`  in  2  per-requester request valid
- `req_ready[1:0]`  out  2  per-requester request accepted this cycle
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  W each  operands of requester 0/1
- `req_op0`, `req_op1`  in  3 each  ALU opcode
- `req_unsig0`, `req_unsig1`  in  1 each  forwarded unchanged to `Alu.unsig`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed
- `rsp_id`  out  1  requester that owns the response
- `rsp_result`  out  W  captured `aluout`
- `rsp_overflow`, `rsp_compout`  out  1 each  captured ALU flags
- `rsp_err`  out  1  illegal opcode
- `ops_done`  out  CNT_W  count of completed responses (wraps)

## Operation
- Legal opcodes: 000 AND, 001 OR, 010 ADD, 100 NOR, 101 XOR, 110 SUB.
- 011 and 111 are illegal. An illegal opcode is still accepted and responded to, with `rsp_err`=1, result 0 and both flags 0.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: arbitration runs. On a grant, latch a/b/op/unsig/id and go to EXEC.
  - EXEC: drive the latched operands into `Alu`. Capture aluout/overflow/compout at the clock edge, then go to RESP.
  - RESP: hold `rsp_*` stable. On `rsp_valid & rsp_ready`, increment `ops_done` and go to IDLE.
- Arbitration: 1-bit priority pointer `prio`, reset 0.
  - Only one requester valid: it is granted.
  - Both valid: requester `prio` is granted.
  - After any grant, `prio` is set to the other requester.
- `req_ready[i]` is high only in IDLE, only for the granted i, and is combinational from `req_valid`/`prio`. At most one bit is set.
- A requester may drop `req_valid` before a grant without penalty. Once granted, it must not be re-granted until RESP completes (single outstanding operation).
- In IDLE and RESP, `Alu` inputs hold the last latched values (no toggling).

## Timing
- Reset (async assert, sync-style deassert is assumed at the top level):
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_compout`=0, `rsp_err`=0, `ops_done`=0.
  - State is IDLE, `prio`=0, latched operands are 0.
- Handshake on edge N (in IDLE) means EXEC in cycle N+1 and `rsp_valid`=1 from cycle N+2. Minimum latency is 2 cycles.
- Throughput is at most one operation per 3 cycles when `rsp_ready` is tied high.
- `rsp_ready` low holds RESP indefinitely. No new grant happens and `req_ready` stays 0.
- `ops_done` wraps from 2^CNT_W−1 to 0 with no flag.
- Reset asserted in EXEC or RESP drops the transaction: no response, counter cleared.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams `OP_AND`, `OP_OR`, `OP_ADD`, `OP_NOR`, `OP_XOR`, `OP_SUB`;
  - the FSM state encoding (2 bits);
  - a function `op_legal(op)`.
- One sub-module: the existing `Alu`, instantiated once inside the arbiter. The arbitration logic stays inline because it is too small to split out.

## Test plan
- Reset, then requester 0 sends ADD with a=32'h7FFF_FFFF, b=1, unsig=0. Required: `rsp_valid` at cycle N+2, `rsp_id`=0, result 32'h8000_0000, `rsp_overflow` equal to the ALU's flag, `ops_done`=1.
- Both requesters valid with SUB, 10−3 (req0) and XOR F0F0_F0F0^FFFF_0000 (req1), `rsp_ready`=1. Required: grant order 0, then 1, then 0. Responses 7 (id 0), 0F0F_F0F0 (id 1).
- Requester 1 sends op 3'b011. Required: `rsp_err`=1, result 0, flags 0, counter still increments.
- Hold `rsp_ready`=0 for 10 cycles while req0 is valid. Required: response stable for all 10 cycles, `req_ready`=00 throughout, grant resumes the cycle after release.
- Assert `rst_n`=0 during EXEC. Required: all outputs at reset values immediately, no response after release, `prio`=0.
- Preload 65535 ops with the counter at 16 bits, then one more. Required: `ops_done` wraps to 0.
